// File: rtl/raizing_linetext_if.sv
// Memory-side bus of the text-layer renderer: row-select/scroll RAM, text VRAM and text ROM.
// The renderer is the master; the RAM/ROM side is the slave.
interface raizing_linetext_if #(
  parameter int MAP_COLS_W = 6
);
  logic [7:0]            SELECT_ADDR;
  logic [15:0]           SELECT_DATA;
  logic [7:0]            SCROLL_ADDR;
  logic [15:0]           SCROLL_DATA;
  logic [MAP_COLS_W+4:0] VRAM_ADDR;
  logic [15:0]           VRAM_DATA;
  logic [13:0]           ROM_ADDR;
  logic                  ROM_CS;
  logic                  ROM_OK;
  logic [15:0]           ROM_DATA;

  modport master (
    output SELECT_ADDR, SCROLL_ADDR, VRAM_ADDR, ROM_ADDR, ROM_CS,
    input  SELECT_DATA, SCROLL_DATA, VRAM_DATA, ROM_OK, ROM_DATA
  );

  modport slave (
    input  SELECT_ADDR, SCROLL_ADDR, VRAM_ADDR, ROM_ADDR, ROM_CS,
    output SELECT_DATA, SCROLL_DATA, VRAM_DATA, ROM_OK, ROM_DATA
  );
endinterface

// File: rtl/raizing_linetext.sv
// Per-line-scrolled 8x8 4bpp text layer: renders one line into a ping-pong buffer, read out next line.
// Build option RAIZING_LINETEXT_OPAQUE_EN: pen 0 draws the palette base colour instead of transparent.
//
// state   | meaning
// IDLE    | waiting for LINE_START
// LREQ    | row-select / scroll address presented
// LWAIT   | two-cycle RAM latency
// CALC    | derive start column, fine scroll, map row and tile row
// TADR    | VRAM address for tile t presented
// TWAIT   | two-cycle VRAM latency
// R0      | ROM request, high pen word
// R1      | ROM request, low pen word
// DRAW    | eight pixel writes
// NEXT    | advance tile, loop or finish
module raizing_linetext #(
  parameter int SCREEN_W   = 320,
  parameter int MAP_COLS_W = 6,
  parameter int XOFFS      = 'h2B,
  parameter int PAL_BASE   = 'h400,
  parameter int PXL_W      = 11
) (
  input  logic                 CLK96,
  input  logic                 RESET96,
  input  logic                 PIXEL_CEN,
  input  logic                 LINE_START,
  input  logic [8:0]           VRENDER,
  input  logic [8:0]           H,
  input  logic                 FLIPX,
  raizing_linetext_if.master   mem,
  output logic [PXL_W-1:0]     PIXEL,
  output logic                 BUSY,
  output logic                 OVERRUN
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_LREQ  = 4'd1;
  localparam logic [3:0] S_LWAIT = 4'd2;
  localparam logic [3:0] S_CALC  = 4'd3;
  localparam logic [3:0] S_TADR  = 4'd4;
  localparam logic [3:0] S_TWAIT = 4'd5;
  localparam logic [3:0] S_R0    = 4'd6;
  localparam logic [3:0] S_R1    = 4'd7;
  localparam logic [3:0] S_DRAW  = 4'd8;
  localparam logic [3:0] S_NEXT  = 4'd9;

  // Two extra tiles cover the partial tiles exposed by fine scroll.
  localparam logic [6:0] NUM_TILES = 7'(SCREEN_W / 8 + 2);
  localparam logic [8:0] SCREEN_W9 = 9'(SCREEN_W);

  logic [3:0]            state_q, state_d;
  logic                  wait_q, wait_d;
  logic                  bank_q, bank_d;
  logic                  overrun_q, overrun_d;
  logic [7:0]            y_q, y_d;
  logic [MAP_COLS_W-1:0] col_q, col_d;
  logic [2:0]            fine_q, fine_d;
  logic [4:0]            row_q, row_d;
  logic [2:0]            frow_q, frow_d;
  logic [6:0]            t_q, t_d;
  logic [2:0]            px_q, px_d;
  logic [5:0]            pal_q, pal_d;
  logic [13:0]           rom_addr_q, rom_addr_d;
  logic                  cs_q, cs_d;
  logic [31:0]           pens_q, pens_d;
  logic [PXL_W-1:0]      pixel_q, pixel_d;

  logic [PXL_W-1:0]      line_mem [2][SCREEN_W];

  logic [15:0]           scroll_sum;
  logic [6:0]            t_inc;
  logic signed [10:0]    sx;
  logic                  sx_vis;
  logic [8:0]            wr_addr;
  logic [3:0]            pen;
  logic [PXL_W-1:0]      wr_data;
  logic                  wr_en;

  assign scroll_sum = mem.SCROLL_DATA + 16'(XOFFS);
  assign t_inc      = t_q + 7'd1;

  // Screen x of the current pixel, negative while fine scroll hides the left edge.
  assign sx      = $signed({1'b0, t_q, px_q}) - $signed({8'b0, fine_q});
  assign sx_vis  = !sx[10] && (sx[9:0] < 10'(SCREEN_W));
  assign wr_addr = FLIPX ? (SCREEN_W9 - 9'd1 - sx[8:0]) : sx[8:0];
  assign pen     = pens_q[{~px_q, 2'b00} +: 4];

`ifdef RAIZING_LINETEXT_OPAQUE_EN
  assign wr_data = PXL_W'(PAL_BASE) + PXL_W'({pal_q, 4'b0000}) + PXL_W'(pen);
`else
  assign wr_data = (pen == 4'd0) ? '0
                 : PXL_W'(PAL_BASE) + PXL_W'({pal_q, 4'b0000}) + PXL_W'(pen);
`endif

  assign wr_en = (state_q == S_DRAW) && sx_vis && !RESET96;

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    bank_d     = bank_q;
    overrun_d  = overrun_q;
    y_d        = y_q;
    col_d      = col_q;
    fine_d     = fine_q;
    row_d      = row_q;
    frow_d     = frow_q;
    t_d        = t_q;
    px_d       = px_q;
    pal_d      = pal_q;
    rom_addr_d = rom_addr_q;
    cs_d       = cs_q;
    pens_d     = pens_q;

    if (LINE_START && state_q != S_IDLE) overrun_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (LINE_START) begin
          bank_d  = ~bank_q;
          y_d     = VRENDER[7:0];
          state_d = S_LREQ;
        end
      end
      S_LREQ: begin
        wait_d  = 1'b0;
        state_d = S_LWAIT;
      end
      S_LWAIT: begin
        wait_d = ~wait_q;
        if (wait_q) state_d = S_CALC;
      end
      S_CALC: begin
        col_d   = scroll_sum[MAP_COLS_W+2:3];
        fine_d  = scroll_sum[2:0];
        row_d   = mem.SELECT_DATA[7:3];
        frow_d  = mem.SELECT_DATA[2:0];
        t_d     = 7'd0;
        state_d = S_TADR;
      end
      S_TADR: begin
        wait_d  = 1'b0;
        state_d = S_TWAIT;
      end
      S_TWAIT: begin
        wait_d = ~wait_q;
        if (wait_q) begin
          rom_addr_d = {mem.VRAM_DATA[9:0], frow_q, 1'b0};
          pal_d      = mem.VRAM_DATA[15:10];
          cs_d       = 1'b1;
          state_d    = S_R0;
        end
      end
      // With CS already dropped, the next cycle raises it again for the other half.
      S_R0: begin
        if (cs_q) begin
          if (mem.ROM_OK) begin
            pens_d[31:16] = mem.ROM_DATA;
            cs_d          = 1'b0;
          end
        end else begin
          rom_addr_d[0] = 1'b1;
          cs_d          = 1'b1;
          state_d       = S_R1;
        end
      end
      S_R1: begin
        if (cs_q) begin
          if (mem.ROM_OK) begin
            pens_d[15:0] = mem.ROM_DATA;
            cs_d         = 1'b0;
          end
        end else begin
          px_d    = 3'd0;
          state_d = S_DRAW;
        end
      end
      S_DRAW: begin
        px_d = px_q + 3'd1;
        if (px_q == 3'd7) state_d = S_NEXT;
      end
      S_NEXT: begin
        t_d     = t_inc;
        col_d   = col_q + 1'b1;
        state_d = (t_inc < NUM_TILES) ? S_TADR : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pixel_d = pixel_q;
    if (PIXEL_CEN) pixel_d = (H < SCREEN_W9) ? line_mem[~bank_q][H] : '0;
  end

  always_ff @(posedge CLK96) begin
    if (RESET96) begin
      state_q    <= S_IDLE;
      wait_q     <= 1'b0;
      bank_q     <= 1'b0;
      overrun_q  <= 1'b0;
      y_q        <= '0;
      col_q      <= '0;
      fine_q     <= '0;
      row_q      <= '0;
      frow_q     <= '0;
      t_q        <= '0;
      px_q       <= '0;
      pal_q      <= '0;
      rom_addr_q <= '0;
      cs_q       <= 1'b0;
      pens_q     <= '0;
      pixel_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      bank_q     <= bank_d;
      overrun_q  <= overrun_d;
      y_q        <= y_d;
      col_q      <= col_d;
      fine_q     <= fine_d;
      row_q      <= row_d;
      frow_q     <= frow_d;
      t_q        <= t_d;
      px_q       <= px_d;
      pal_q      <= pal_d;
      rom_addr_q <= rom_addr_d;
      cs_q       <= cs_d;
      pens_q     <= pens_d;
      pixel_q    <= pixel_d;
    end
  end

  // Line buffer survives reset so the displayed line is not blanked.
  always_ff @(posedge CLK96) begin
    if (wr_en) line_mem[bank_q][wr_addr] <= wr_data;
  end

  assign mem.SELECT_ADDR = y_q;
  assign mem.SCROLL_ADDR = y_q;
  assign mem.VRAM_ADDR   = {row_q, col_q};
  assign mem.ROM_ADDR    = rom_addr_q;
  assign mem.ROM_CS      = cs_q;
  assign PIXEL           = pixel_q;
  assign BUSY            = (state_q != S_IDLE);
  assign OVERRUN         = overrun_q;

  logic unused_bits;
  assign unused_bits = ^{VRENDER[8], mem.SELECT_DATA[15:8], scroll_sum[15:MAP_COLS_W+3]};

endmodule

// File: tb/tb_raizing_linetext.sv
// Directed bench for raizing_linetext: RAM/ROM models with fixed latency and adjustable ROM wait.
module tb_raizing_linetext;
  logic        CLK96 = 1'b0;
  logic        RESET96, PIXEL_CEN, LINE_START, FLIPX;
  logic [8:0]  VRENDER, H;
  logic [10:0] PIXEL;
  logic        BUSY, OVERRUN;

  int checks = 0;
  int errors = 0;

  always #5 CLK96 = ~CLK96;

  raizing_linetext_if #(.MAP_COLS_W(6)) bus ();

  raizing_linetext dut (
    .CLK96      (CLK96),
    .RESET96    (RESET96),
    .PIXEL_CEN  (PIXEL_CEN),
    .LINE_START (LINE_START),
    .VRENDER    (VRENDER),
    .H          (H),
    .FLIPX      (FLIPX),
    .mem        (bus),
    .PIXEL      (PIXEL),
    .BUSY       (BUSY),
    .OVERRUN    (OVERRUN)
  );

  logic [15:0] sel_mem [256];
  logic [15:0] scr_mem [256];
  logic [15:0] vram    [2048];
  logic [15:0] rom     [16384];
  logic [15:0] sel_p1, sel_p2, scr_p1, scr_p2, vr_p1, vr_p2;
  int          rom_wait = 0;
  int          wcnt = 0;
  bit          cs_prev = 1'b0;
  bit          rec_en = 1'b0;
  int          cols[$];

  always @(posedge CLK96) begin
    sel_p1 <= sel_mem[bus.SELECT_ADDR];
    sel_p2 <= sel_p1;
    scr_p1 <= scr_mem[bus.SCROLL_ADDR];
    scr_p2 <= scr_p1;
    vr_p1  <= vram[bus.VRAM_ADDR];
    vr_p2  <= vr_p1;
    if (!bus.ROM_CS || bus.ROM_OK) wcnt <= 0;
    else wcnt <= wcnt + 1;
    cs_prev <= bus.ROM_CS;
    if (rec_en && bus.ROM_CS && !cs_prev && !bus.ROM_ADDR[0])
      cols.push_back(int'(bus.VRAM_ADDR[5:0]));
  end

  assign bus.SELECT_DATA = sel_p2;
  assign bus.SCROLL_DATA = scr_p2;
  assign bus.VRAM_DATA   = vr_p2;
  assign bus.ROM_OK      = bus.ROM_CS && (wcnt == rom_wait);
  assign bus.ROM_DATA    = rom[bus.ROM_ADDR];

  task automatic render(output int cyc);
    @(negedge CLK96) LINE_START = 1'b1;
    @(negedge CLK96) LINE_START = 1'b0;
    cyc = 1;
    while (BUSY && cyc < 5000) begin
      @(negedge CLK96);
      cyc++;
    end
    if (BUSY) begin
      checks++; errors++;
      $display("FAIL render_timeout: BUSY still %0b after %0d cycles, required 0", BUSY, cyc);
    end
  endtask

  // Render a blank line (row 31) so the previous render becomes the read bank.
  task automatic swap();
    int c;
    VRENDER = 9'd1;
    render(c);
    VRENDER = 9'd0;
  endtask

  task automatic read_px(input logic [8:0] h, output logic [10:0] v);
    @(negedge CLK96);
    H = h;
    PIXEL_CEN = 1'b1;
    @(negedge CLK96);
    PIXEL_CEN = 1'b0;
    v = PIXEL;
  endtask

  task automatic test_reset();
    RESET96 = 1'b1;
    repeat (3) @(negedge CLK96);
    RESET96 = 1'b0;
    @(negedge CLK96);
    checks++;
    if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b, required 0", BUSY); end
    checks++;
    if (OVERRUN !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %0b, required 0", OVERRUN); end
    checks++;
    if (PIXEL !== 11'h0) begin errors++; $display("FAIL reset_pixel: got %h, required 000", PIXEL); end
    checks++;
    if (bus.ROM_CS !== 1'b0 || bus.ROM_ADDR !== 14'h0 || bus.VRAM_ADDR !== 11'h0 || bus.SELECT_ADDR !== 8'h0) begin
      errors++;
      $display("FAIL reset_bus: cs=%0b rom=%h vram=%h sel=%h, required all zero",
               bus.ROM_CS, bus.ROM_ADDR, bus.VRAM_ADDR, bus.SELECT_ADDR);
    end
  endtask

  task automatic test_basic();
    int c;
    logic [10:0] v;
    scr_mem[0] = 16'hFFD5;
    render(c);
    checks++;
    if (c !== 677) begin errors++; $display("FAIL basic_latency: BUSY cleared at cycle %0d, required 677", c); end
    swap();
    for (int i = 0; i < 8; i++) begin
      read_px(9'(i), v);
      checks++;
      if (v !== 11'(11'h421 + i)) begin
        errors++; $display("FAIL basic_px H=%0d: got %h, required %h", i, v, 11'(11'h421 + i));
      end
    end
    read_px(9'd8, v);
    checks++;
    if (v !== 11'h0) begin errors++; $display("FAIL basic_px H=8: got %h, required 000", v); end
    read_px(9'd7, v);
    read_px(9'd320, v);
    checks++;
    if (v !== 11'h0) begin errors++; $display("FAIL basic_offscreen H=320: got %h, required 000", v); end
    read_px(9'd0, v);
    read_px(9'd511, v);
    checks++;
    if (v !== 11'h0) begin errors++; $display("FAIL basic_offscreen H=511: got %h, required 000", v); end
  endtask

  task automatic test_flipx();
    int c;
    logic [10:0] v;
    FLIPX = 1'b1;
    render(c);
    swap();
    read_px(9'd319, v);
    checks++;
    if (v !== 11'h421) begin errors++; $display("FAIL flipx H=319: got %h, required 421", v); end
    read_px(9'd312, v);
    checks++;
    if (v !== 11'h428) begin errors++; $display("FAIL flipx H=312: got %h, required 428", v); end
    read_px(9'd0, v);
    checks++;
    if (v !== 11'h0) begin errors++; $display("FAIL flipx H=0: got %h, required 000", v); end
    FLIPX = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [10:0] v;
    read_px(9'd319, v);
    VRENDER = 9'd1;
    @(negedge CLK96) LINE_START = 1'b1;
    @(negedge CLK96) LINE_START = 1'b0;
    repeat (48) @(negedge CLK96);
    LINE_START = 1'b1;
    @(negedge CLK96) LINE_START = 1'b0;
    repeat (49) @(negedge CLK96);
    checks++;
    if (OVERRUN !== 1'b1) begin errors++; $display("FAIL midreset_pre_overrun: got %0b, required 1", OVERRUN); end
    RESET96 = 1'b1;
    @(negedge CLK96) RESET96 = 1'b0;
    VRENDER = 9'd0;
    checks++;
    if (BUSY !== 1'b0 || OVERRUN !== 1'b0 || PIXEL !== 11'h0) begin
      errors++;
      $display("FAIL midreset_state: busy=%0b overrun=%0b pixel=%h, required 0 0 000", BUSY, OVERRUN, PIXEL);
    end
    repeat (800) @(negedge CLK96);
    checks++;
    if (BUSY !== 1'b0) begin errors++; $display("FAIL midreset_idle: BUSY got %0b, required 0", BUSY); end
    read_px(9'd319, v);
    checks++;
    if (v !== 11'h421) begin errors++; $display("FAIL midreset_keep H=319: got %h, required 421", v); end
    read_px(9'd312, v);
    checks++;
    if (v !== 11'h428) begin errors++; $display("FAIL midreset_keep H=312: got %h, required 428", v); end
  endtask

  task automatic test_fine_scroll();
    int c;
    logic [10:0] v;
    logic [10:0] exp_l [7];
    logic [10:0] exp_r [4];
    exp_l = '{11'h424, 11'h425, 11'h426, 11'h427, 11'h428, 11'h0, 11'h0};
    exp_r = '{11'h0, 11'h411, 11'h412, 11'h413};
    scr_mem[0] = 16'hFFD8;
    vram[40]   = 16'h0402;
    rom[32]    = 16'h1234;
    rom[33]    = 16'h5678;
    render(c);
    swap();
    for (int i = 0; i < 7; i++) begin
      read_px(9'(i), v);
      checks++;
      if (v !== exp_l[i]) begin errors++; $display("FAIL fine_left H=%0d: got %h, required %h", i, v, exp_l[i]); end
    end
    for (int i = 0; i < 4; i++) begin
      read_px(9'(316 + i), v);
      checks++;
      if (v !== exp_r[i]) begin errors++; $display("FAIL fine_right H=%0d: got %h, required %h", 316 + i, v, exp_r[i]); end
    end
    vram[40]   = 16'h0;
    scr_mem[0] = 16'hFFD5;
  endtask

  task automatic test_map_wrap();
    int c;
    logic [10:0] v;
    scr_mem[0] = 16'h01CD;
    vram[0]    = 16'h0;
    vram[63]   = 16'h0801;
    cols.delete();
    rec_en = 1'b1;
    render(c);
    rec_en = 1'b0;
    checks++;
    if (cols.size() !== 42) begin
      errors++; $display("FAIL wrap_count: got %0d tile fetches, required 42", cols.size());
    end else begin
      checks++;
      if (cols[0] !== 63 || cols[1] !== 0 || cols[2] !== 1 || cols[41] !== 40) begin
        errors++;
        $display("FAIL wrap_cols: got %0d %0d %0d .. %0d, required 63 0 1 .. 40", cols[0], cols[1], cols[2], cols[41]);
      end
    end
    swap();
    for (int i = 0; i < 8; i++) begin
      read_px(9'(i), v);
      checks++;
      if (v !== 11'(11'h421 + i)) begin
        errors++; $display("FAIL wrap_px H=%0d: got %h, required %h", i, v, 11'(11'h421 + i));
      end
    end
    vram[63]   = 16'h0;
    vram[0]    = 16'h0801;
    scr_mem[0] = 16'hFFD5;
  endtask

  task automatic test_rom_stall();
    int cyc;
    logic [10:0] v;
    rom_wait = 5;
    @(negedge CLK96) LINE_START = 1'b1;
    @(negedge CLK96) LINE_START = 1'b0;
    cyc = 1;
    while (BUSY && cyc < 5000) begin
      LINE_START = (cyc == 200);
      @(negedge CLK96);
      cyc++;
    end
    LINE_START = 1'b0;
    checks++;
    if (cyc !== 1097) begin errors++; $display("FAIL stall_latency: BUSY cleared at cycle %0d, required 1097", cyc); end
    checks++;
    if (OVERRUN !== 1'b1) begin errors++; $display("FAIL stall_overrun: got %0b, required 1", OVERRUN); end
    swap();
    for (int i = 0; i < 8; i++) begin
      read_px(9'(i), v);
      checks++;
      if (v !== 11'(11'h421 + i)) begin
        errors++; $display("FAIL stall_px H=%0d: got %h, required %h", i, v, 11'(11'h421 + i));
      end
    end
    read_px(9'd8, v);
    checks++;
    if (v !== 11'h0) begin errors++; $display("FAIL stall_px H=8: got %h, required 000", v); end
    checks++;
    if (OVERRUN !== 1'b1) begin errors++; $display("FAIL stall_overrun_sticky: got %0b, required 1", OVERRUN); end
    rom_wait = 0;
  endtask

  initial begin
    RESET96    = 1'b1;
    PIXEL_CEN  = 1'b0;
    LINE_START = 1'b0;
    FLIPX      = 1'b0;
    VRENDER    = 9'd0;
    H          = 9'd0;
    for (int i = 0; i < 256; i++) begin sel_mem[i] = 16'h0; scr_mem[i] = 16'h0; end
    for (int i = 0; i < 2048; i++) vram[i] = 16'h0;
    for (int i = 0; i < 16384; i++) rom[i] = 16'h0;
    sel_mem[1] = 16'h00F8;
    vram[0]    = 16'h0801;
    rom[16]    = 16'h1234;
    rom[17]    = 16'h5678;

    test_reset();
    test_basic();
    test_flipx();
    test_reset_mid();
    test_fine_scroll();
    test_map_wrap();
    test_rom_stall();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
